// File: rtl/rv32v_types_pkg.sv
// Shared RV32V vector types used by the load/store unit.
package rv32v_types_pkg;

  typedef enum logic [1:0] {
    SEW8  = 2'd0,
    SEW16 = 2'd1,
    SEW32 = 2'd2
  } sew_t;

endpackage

// File: rtl/vlsu_element_sequencer.sv
// Walks a vector memory op two elements per step, handing address pairs to the
// address scheduler and tracking per-lane arrivals, faults and completion.
module vlsu_element_sequencer
  import rv32v_types_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        start,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [31:0] base_addr,
  input  logic [31:0] stride,
  input  logic        strided,
  input  logic [5:0]  vl,
  input  sew_t        sew,
  input  logic [31:0] rd_data0,
  input  logic [31:0] rd_data1,
  input  logic        arrived0,
  input  logic        arrived1,
  input  logic        exception,
  input  logic        sched_busy,
  output logic [31:0] addr0,
  output logic [31:0] addr1,
  output logic [31:0] storedata0,
  output logic [31:0] storedata1,
  output logic        load,
  output logic        store,
  output logic        lane1_en,
  output logic        returnex,
  output logic [4:0]  rd_idx0,
  output logic [4:0]  rd_idx1,
  output logic        wb_en0,
  output logic        wb_en1,
  output logic [4:0]  wb_idx0,
  output logic [4:0]  wb_idx1,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [5:0]  fault_idx
);

  localparam int unsigned AW = 32;
  localparam int unsigned EW = 6;
  localparam int unsigned IW = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    ABORT  = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t        state, state_n;
  logic          op_load, op_load_n;
  logic          op_store, op_store_n;
  logic [AW-1:0] stride_q, stride_n;
  logic [EW-1:0] vl_q, vl_n;
  logic [EW-1:0] e_q, e_n;
  logic [AW-1:0] cur_addr_q, cur_addr_n;
  logic          got0_q, got0_n;
  logic          got1_q, got1_n;
  logic          fault_q, fault_n;
  logic [EW-1:0] fault_idx_q, fault_idx_n;

  logic          in_run;
  logic [EW-1:0] e_p1;
  logic          lane1;

  assign in_run = (state == RUN);
  assign e_p1   = e_q + EW'(1);
  assign lane1  = in_run && (e_p1 < vl_q);

  // Lane outputs are only meaningful in RUN; elsewhere they are held at zero.
  assign addr0      = in_run ? cur_addr_q : '0;
  assign addr1      = in_run ? (lane1 ? cur_addr_q + stride_q : cur_addr_q) : '0;
  assign rd_idx0    = in_run ? e_q[IW-1:0] : '0;
  assign rd_idx1    = in_run ? e_p1[IW-1:0] : '0;
  assign storedata0 = in_run ? rd_data0 : '0;
  assign storedata1 = in_run ? (lane1 ? rd_data1 : rd_data0) : '0;
  assign load       = in_run & op_load;
  assign store      = in_run & op_store;
  assign lane1_en   = lane1;
  assign returnex   = (state == ABORT);
  assign done       = (state == FINISH);
  assign busy       = (state != IDLE);
  assign wb_en0     = in_run & op_load & arrived0 & ~exception;
  assign wb_en1     = in_run & op_load & arrived1 & lane1 & ~exception;
  assign wb_idx0    = rd_idx0;
  assign wb_idx1    = rd_idx1;
  assign fault      = fault_q;
  assign fault_idx  = fault_idx_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= IDLE;
      op_load     <= 1'b0;
      op_store    <= 1'b0;
      stride_q    <= '0;
      vl_q        <= '0;
      e_q         <= '0;
      cur_addr_q  <= '0;
      got0_q      <= 1'b0;
      got1_q      <= 1'b0;
      fault_q     <= 1'b0;
      fault_idx_q <= '0;
    end else begin
      state       <= state_n;
      op_load     <= op_load_n;
      op_store    <= op_store_n;
      stride_q    <= stride_n;
      vl_q        <= vl_n;
      e_q         <= e_n;
      cur_addr_q  <= cur_addr_n;
      got0_q      <= got0_n;
      got1_q      <= got1_n;
      fault_q     <= fault_n;
      fault_idx_q <= fault_idx_n;
    end
  end

  // Next-state logic; a pair completes counting this cycle's arrivals.
  always_comb begin
    logic          got0_c;
    logic          got1_c;
    logic          pair_done;
    logic [EW-1:0] e_adv;

    state_n     = state;
    op_load_n   = op_load;
    op_store_n  = op_store;
    stride_n    = stride_q;
    vl_n        = vl_q;
    e_n         = e_q;
    cur_addr_n  = cur_addr_q;
    got0_n      = got0_q;
    got1_n      = got1_q;
    fault_n     = fault_q;
    fault_idx_n = fault_idx_q;

    got0_c    = got0_q | arrived0;
    got1_c    = got1_q | (arrived1 & lane1);
    pair_done = got0_c & (got1_c | ~lane1);
    e_adv     = e_q + EW'(2);

    case (state)
      IDLE: begin
        if (start && !sched_busy) begin
          fault_n     = 1'b0;
          fault_idx_n = '0;
          if (vl == '0) begin
            state_n = FINISH;
          end else begin
            state_n    = RUN;
            op_load_n  = is_load;
            op_store_n = is_store;
            stride_n   = strided ? stride : (AW'(1) << sew);
            vl_n       = vl;
            e_n        = '0;
            cur_addr_n = base_addr;
            got0_n     = 1'b0;
            got1_n     = 1'b0;
          end
        end
      end
      RUN: begin
        if (exception) begin
          fault_n     = 1'b1;
          fault_idx_n = got0_q ? e_p1 : e_q;
          got0_n      = 1'b0;
          got1_n      = 1'b0;
          state_n     = ABORT;
        end else if (pair_done) begin
          e_n        = e_adv;
          cur_addr_n = cur_addr_q + (stride_q << 1);
          got0_n     = 1'b0;
          got1_n     = 1'b0;
          if (e_adv >= vl_q) state_n = FINISH;
        end else begin
          got0_n = got0_c;
          got1_n = got1_c;
        end
      end
      ABORT:   state_n = FINISH;
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_vlsu_element_sequencer.sv
// Randomised self-checking bench for vlsu_element_sequencer against an
// element-list reference model of the memory op.
module tb_vlsu_element_sequencer;
  import rv32v_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        start, is_load, is_store, strided;
  logic [31:0] base_addr, stride;
  logic [5:0]  vl;
  sew_t        sew;
  logic [31:0] rd_data0, rd_data1;
  logic        arrived0, arrived1, exception, sched_busy;
  logic [31:0] addr0, addr1, storedata0, storedata1;
  logic        load, store, lane1_en, returnex;
  logic [4:0]  rd_idx0, rd_idx1, wb_idx0, wb_idx1;
  logic        wb_en0, wb_en1, busy, done, fault;
  logic [5:0]  fault_idx;

  logic [31:0] regfile [32];
  logic [1:0]  script_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          run_cycles;

  always #5 CLK = ~CLK;

  assign rd_data0 = regfile[rd_idx0];
  assign rd_data1 = regfile[rd_idx1];

  vlsu_element_sequencer dut (
    .CLK(CLK), .nRST(nRST), .start(start), .is_load(is_load), .is_store(is_store),
    .base_addr(base_addr), .stride(stride), .strided(strided), .vl(vl), .sew(sew),
    .rd_data0(rd_data0), .rd_data1(rd_data1), .arrived0(arrived0), .arrived1(arrived1),
    .exception(exception), .sched_busy(sched_busy), .addr0(addr0), .addr1(addr1),
    .storedata0(storedata0), .storedata1(storedata1), .load(load), .store(store),
    .lane1_en(lane1_en), .returnex(returnex), .rd_idx0(rd_idx0), .rd_idx1(rd_idx1),
    .wb_en0(wb_en0), .wb_en1(wb_en1), .wb_idx0(wb_idx0), .wb_idx1(wb_idx1),
    .busy(busy), .done(done), .fault(fault), .fault_idx(fault_idx)
  );

  // Runs one op; the model is the element address list base + i*stride_eff
  // walked two at a time, with the scheduler's arrivals chosen by script or at random.
  task automatic run_op(input logic ld, input logic [31:0] base, input logic [31:0] strd,
                        input logic strd_en, input int vl_i, input sew_t sew_i,
                        input int exc_after, input logic rnd_start);
    logic [31:0] se, ea0, ea1;
    logic [1:0]  sc;
    logic        rcv0, rcv1, a0, a1, ex, ln1, exc_fired, w0, w1;
    logic [5:0]  exp_fidx;
    int          p, e, sent, phase;
    for (int i = 0; i < 32; i++) regfile[i] = $urandom();
    se = strd_en ? strd : (32'd1 << 2'(sew_i));
    start = 1'b1; is_load = ld; is_store = ~ld; base_addr = base; stride = strd;
    strided = strd_en; vl = 6'(vl_i); sew = sew_i; sched_busy = 1'b0;
    arrived0 = 1'b0; arrived1 = 1'b0; exception = 1'b0;
    @(posedge CLK); #1;
    start = 1'b0;
    phase = (vl_i == 0) ? 2 : 0;
    p = 0; rcv0 = 1'b0; rcv1 = 1'b0; sent = 0; exc_fired = 1'b0; exp_fidx = '0; run_cycles = 0;
    for (int cyc = 0; cyc < 400 && phase != 3; cyc++) begin
      e   = 2 * p;
      ln1 = (e + 1 < vl_i);
      if (phase == 0) begin
        run_cycles++;
        ea0 = base + 32'(e) * se;
        ea1 = ln1 ? base + 32'(e + 1) * se : ea0;
        n_checks++;
        if ({load, store, busy, done, returnex} !== {ld, ~ld, 1'b1, 1'b0, 1'b0}) begin
          n_fail++; $display("FAIL run_ctrl e=%0d: got ld/st/busy/done/rex=%b required %b", e,
                             {load, store, busy, done, returnex}, {ld, ~ld, 3'b100});
        end
        n_checks++;
        if (addr0 !== ea0 || addr1 !== ea1) begin
          n_fail++; $display("FAIL addr e=%0d: got %h,%h required %h,%h", e, addr0, addr1, ea0, ea1);
        end
        n_checks++;
        if (lane1_en !== ln1 || rd_idx0 !== 5'(e) || rd_idx1 !== 5'(e + 1)) begin
          n_fail++; $display("FAIL lane_idx e=%0d: got en=%b idx=%0d,%0d required en=%b idx=%0d,%0d",
                             e, lane1_en, rd_idx0, rd_idx1, ln1, 5'(e), 5'(e + 1));
        end
        n_checks++;
        if (storedata0 !== regfile[e] || storedata1 !== (ln1 ? regfile[e + 1] : regfile[e])) begin
          n_fail++; $display("FAIL storedata e=%0d: got %h,%h required %h,%h", e, storedata0,
                             storedata1, regfile[e], ln1 ? regfile[e + 1] : regfile[e]);
        end
        ex = (exc_after >= 0) && (sent == exc_after);
        if (script_q.size() > 0) sc = script_q.pop_front();
        else sc = 2'($urandom_range(0, 3));
        a0 = sc[0] & ~rcv0;
        a1 = sc[1] & ~rcv1;
        arrived0 = a0; arrived1 = a1; exception = ex;
        if (rnd_start) start = 1'($urandom_range(0, 1));
        #2;
        w0 = ld & a0 & ~ex;
        w1 = ld & a1 & ln1 & ~ex;
        n_checks++;
        if (wb_en0 !== w0 || wb_en1 !== w1) begin
          n_fail++; $display("FAIL wb_en e=%0d: got %b%b required %b%b", e, wb_en0, wb_en1, w0, w1);
        end
        if (w0 || w1) begin
          n_checks++;
          if ((w0 && wb_idx0 !== 5'(e)) || (w1 && wb_idx1 !== 5'(e + 1))) begin
            n_fail++; $display("FAIL wb_idx e=%0d: got %0d,%0d", e, wb_idx0, wb_idx1);
          end
        end
        if (ex) begin
          exp_fidx = rcv0 ? 6'(e + 1) : 6'(e);
          exc_fired = 1'b1;
          phase = 1;
        end else begin
          if (a0) begin rcv0 = 1'b1; sent++; end
          if (a1 && ln1) begin rcv1 = 1'b1; sent++; end
          if (rcv0 && (rcv1 || !ln1)) begin
            p++; rcv0 = 1'b0; rcv1 = 1'b0;
            if (2 * p >= vl_i) phase = 2;
          end
        end
      end else if (phase == 1) begin
        arrived0 = 1'b0; arrived1 = 1'b0; exception = 1'b0; start = 1'b0;
        n_checks++;
        if ({returnex, load, store, busy, done} !== 5'b10010) begin
          n_fail++; $display("FAIL abort: got rex/ld/st/busy/done=%b required 10010",
                             {returnex, load, store, busy, done});
        end
        phase = 2;
      end else begin
        arrived0 = 1'b0; arrived1 = 1'b0; exception = 1'b0; start = 1'b0;
        n_checks++;
        if ({done, busy, returnex, load, store} !== 5'b11000) begin
          n_fail++; $display("FAIL finish: got done/busy/rex/ld/st=%b required 11000",
                             {done, busy, returnex, load, store});
        end
        if (vl_i > 0) begin
          n_checks++;
          if (fault !== exc_fired || (exc_fired && fault_idx !== exp_fidx)) begin
            n_fail++; $display("FAIL fault: got %b idx %0d required %b idx %0d", fault, fault_idx,
                               exc_fired, exp_fidx);
          end
        end
        phase = 3;
      end
      @(posedge CLK); #1;
    end
    n_checks++;
    if (phase != 3) begin
      n_fail++; $display("FAIL op_timeout: got phase %0d required 3", phase);
    end
    n_checks++;
    if ({busy, done, load, store} !== 4'b0000) begin
      n_fail++; $display("FAIL idle_after: got busy/done/ld/st=%b required 0000", {busy, done, load, store});
    end
    script_q.delete();
  endtask

  task automatic test_reset();
    n_checks++;
    if ({busy, done, load, store, returnex, fault, wb_en0, wb_en1} !== 8'h00 ||
        addr0 !== 32'h0 || fault_idx !== 6'h0) begin
      n_fail++; $display("FAIL reset: got ctrl=%b addr0=%h fidx=%0d required zeros",
                         {busy, done, load, store, returnex, fault, wb_en0, wb_en1}, addr0, fault_idx);
    end
  endtask

  task automatic test_unit_stride_load();
    script_q = '{2'b01, 2'b10, 2'b01, 2'b10};
    run_op(1'b1, 32'h1000, 32'h0, 1'b0, 4, SEW32, -1, 1'b0);
    n_checks++;
    if (run_cycles != 4 || fault !== 1'b0) begin
      n_fail++; $display("FAIL unit_load: got cycles=%0d fault=%b required 4 0", run_cycles, fault);
    end
  endtask

  task automatic test_strided_store();
    script_q = '{2'b11, 2'b11};
    run_op(1'b0, 32'h2000, 32'h10, 1'b1, 3, SEW8, -1, 1'b0);
    n_checks++;
    if (run_cycles != 2) begin
      n_fail++; $display("FAIL strided_store: got cycles=%0d required 2", run_cycles);
    end
  endtask

  task automatic test_arrival_order();
    script_q = '{2'b10, 2'b01, 2'b11};
    run_op(1'b1, 32'h3000, 32'h0, 1'b0, 4, SEW16, -1, 1'b0);
    n_checks++;
    if (run_cycles != 3) begin
      n_fail++; $display("FAIL arrival_order: got cycles=%0d required 3", run_cycles);
    end
  endtask

  task automatic test_exception();
    script_q = '{2'b01, 2'b10, 2'b01};
    run_op(1'b1, 32'h4000, 32'h0, 1'b0, 4, SEW32, 3, 1'b0);
    n_checks++;
    if (fault !== 1'b1 || fault_idx !== 6'd3 || run_cycles != 4) begin
      n_fail++; $display("FAIL exception: got fault=%b idx=%0d cycles=%0d required 1 3 4",
                         fault, fault_idx, run_cycles);
    end
  endtask

  task automatic test_wrap();
    run_op(1'b1, 32'hFFFF_FFF8, 32'h0, 1'b0, 4, SEW32, -1, 1'b0);
    n_checks++;
    if (fault !== 1'b0) begin
      n_fail++; $display("FAIL wrap: got fault=%b required 0", fault);
    end
  endtask

  task automatic test_vl_zero();
    run_op(1'b0, 32'h5000, 32'h0, 1'b0, 0, SEW8, -1, 1'b0);
    n_checks++;
    if (run_cycles != 0) begin
      n_fail++; $display("FAIL vl_zero: got run cycles=%0d required 0", run_cycles);
    end
  endtask

  task automatic test_sched_busy();
    start = 1'b1; sched_busy = 1'b1; is_load = 1'b1; is_store = 1'b0; vl = 6'd4;
    @(posedge CLK); #1;
    start = 1'b0; sched_busy = 1'b0;
    n_checks++;
    if ({busy, load, done} !== 3'b000) begin
      n_fail++; $display("FAIL sched_busy: got busy/ld/done=%b required 000", {busy, load, done});
    end
  endtask

  task automatic test_reset_mid_run();
    logic saw_done;
    start = 1'b1; is_load = 1'b1; is_store = 1'b0; base_addr = 32'h6000; strided = 1'b0;
    vl = 6'd8; sew = SEW32; arrived0 = 1'b0; arrived1 = 1'b0; exception = 1'b0;
    @(posedge CLK); #1;
    start = 1'b0; arrived0 = 1'b1; arrived1 = 1'b1;
    @(posedge CLK); #1;
    nRST = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, load, store, returnex, lane1_en, wb_en0, wb_en1, fault} !== 9'h0 ||
        {addr0, addr1, storedata0, storedata1} !== 128'h0 ||
        {rd_idx0, rd_idx1, wb_idx0, wb_idx1, fault_idx} !== 26'h0) begin
      n_fail++; $display("FAIL reset_mid_run: got ctrl=%b addr0=%h addr1=%h required zeros",
                         {busy, done, load, store, returnex, lane1_en, wb_en0, wb_en1, fault},
                         addr0, addr1);
    end
    arrived0 = 1'b0; arrived1 = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      saw_done |= done | returnex;
      @(posedge CLK); #1;
    end
    n_checks++;
    if (saw_done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_no_done: got done_seen=%b busy=%b required 0 0", saw_done, busy);
    end
  endtask

  task automatic test_random();
    int v, ex;
    for (int k = 0; k < 30; k++) begin
      v  = $urandom_range(0, 32);
      ex = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2 * v) : -1;
      run_op(1'($urandom_range(0, 1)), $urandom(), $urandom(), 1'($urandom_range(0, 1)), v,
             sew_t'(2'($urandom_range(0, 2))), ex, 1'b1);
    end
  endtask

  initial begin
    nRST = 1'b0; start = 1'b0; is_load = 1'b0; is_store = 1'b0; base_addr = '0; stride = '0;
    strided = 1'b0; vl = '0; sew = SEW8; arrived0 = 1'b0; arrived1 = 1'b0; exception = 1'b0;
    sched_busy = 1'b0;
    for (int i = 0; i < 32; i++) regfile[i] = '0;
    repeat (2) @(posedge CLK);
    #1;
    test_reset();
    nRST = 1'b1;
    @(posedge CLK); #1;
    test_unit_stride_load();
    test_strided_store();
    test_arrival_order();
    test_exception();
    test_wrap();
    test_vl_zero();
    test_sched_busy();
    test_reset_mid_run();
    test_random();
    test_unit_stride_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
